// File: rtl/hp48_bus_ctrl.sv
// hp48_bus_ctrl: HP48 (Saturn) bus transaction sequencer.
// A request issues one LOAD_PC/LOAD_DP with the start address, then req_len+1
// PC/DP READ or WRITE commands. Reads add a one-cycle DRAIN so that the last
// registered device response can be captured.
// Optional feature: define HP48_BUS_ERR_CHECK_EN to flag bus cycles in which
// no device drove bus_active (sticky err until the next accepted request).
//
// Handshake: req is sampled only while the controller is IDLE (busy = 0);
// any req seen while busy is ignored. Completion is a single-cycle done pulse
// in the first IDLE cycle, and a req present in that cycle is accepted.
module hp48_bus_ctrl #(
  parameter int MAX_NIBBLES = 16
) (
  input  logic                     strobe,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     req_write,
  input  logic                     req_use_pc,
  input  logic [19:0]              req_addr,
  input  logic [3:0]               req_len,
  input  logic [4*MAX_NIBBLES-1:0] wr_data,
  input  logic [3:0]               bus_nibble_in,
  input  logic                     bus_active,
  output logic [3:0]               bus_command,
  output logic [19:0]              bus_address,
  output logic [3:0]               bus_nibble_out,
  output logic [4*MAX_NIBBLES-1:0] rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               state_dbg
);

  localparam logic [3:0] BUSCMD_NOP      = 4'h0;
  localparam logic [3:0] BUSCMD_PC_READ  = 4'h2;
  localparam logic [3:0] BUSCMD_DP_READ  = 4'h3;
  localparam logic [3:0] BUSCMD_PC_WRITE = 4'h4;
  localparam logic [3:0] BUSCMD_DP_WRITE = 4'h5;
  localparam logic [3:0] BUSCMD_LOAD_PC  = 4'h6;
  localparam logic [3:0] BUSCMD_LOAD_DP  = 4'h7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t     state;
  logic       write_q;
  logic       use_pc_q;
  logic [3:0] len_q;
  logic [3:0] count;

  logic [3:0] xfer_cmd;
  logic [3:0] nib_sel;
  logic [3:0] wr_nib;
  logic       cap_en;
  logic [3:0] cap_idx;

  assign state_dbg = state;

  // Transfer command for the latched direction and pointer.
  always_comb begin
    xfer_cmd = BUSCMD_NOP;
    if (use_pc_q) xfer_cmd = write_q ? BUSCMD_PC_WRITE : BUSCMD_PC_READ;
    else          xfer_cmd = write_q ? BUSCMD_DP_WRITE : BUSCMD_DP_READ;
  end

  // Next write nibble: nibble 0 when entering XFER, count+1 while in XFER.
  always_comb begin
    nib_sel = (state == LOAD) ? 4'd0 : count + 4'd1;
    wr_nib  = 4'h0;
    for (int k = 0; k < MAX_NIBBLES; k++) begin
      if (k == int'(nib_sel)) wr_nib = wr_data[4*k +: 4];
    end
  end

  // Devices answer one cycle after sampling a read command, so nibble k is
  // captured two edges after command k was launched; DRAIN takes the last.
  always_comb begin
    cap_en  = ((state == XFER) && !write_q && (count != 4'd0)) || (state == DRAIN);
    cap_idx = (state == DRAIN) ? len_q : count - 4'd1;
  end

`ifdef HP48_BUS_ERR_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_bus_active;
  assign unused_bus_active = bus_active;
  assign err = 1'b0;
`endif

  // Main sequencer: state, registered bus outputs and read capture.
  always_ff @(posedge strobe or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      write_q        <= 1'b0;
      use_pc_q       <= 1'b0;
      len_q          <= 4'd0;
      count          <= 4'd0;
      bus_command    <= BUSCMD_NOP;
      bus_address    <= 20'h0;
      bus_nibble_out <= 4'h0;
      rd_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef HP48_BUS_ERR_CHECK_EN
      err_q          <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (cap_en) begin
        for (int k = 0; k < MAX_NIBBLES; k++) begin
          if (k == int'(cap_idx)) rd_data[4*k +: 4] <= bus_nibble_in;
        end
      end
      case (state)
        IDLE: begin
          bus_command <= BUSCMD_NOP;
          busy        <= 1'b0;
          if (req) begin
            state       <= LOAD;
            write_q     <= req_write;
            use_pc_q    <= req_use_pc;
            len_q       <= req_len;
            count       <= 4'd0;
            bus_command <= req_use_pc ? BUSCMD_LOAD_PC : BUSCMD_LOAD_DP;
            bus_address <= req_addr;
            busy        <= 1'b1;
`ifdef HP48_BUS_ERR_CHECK_EN
            err_q       <= 1'b0;
`endif
          end
        end
        LOAD: begin
          state          <= XFER;
          bus_command    <= xfer_cmd;
          bus_nibble_out <= wr_nib;
        end
        XFER: begin
`ifdef HP48_BUS_ERR_CHECK_EN
          if (!bus_active) err_q <= 1'b1;
`endif
          if (count == len_q) begin
            bus_command <= BUSCMD_NOP;
            if (write_q) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            count          <= count + 4'd1;
            bus_nibble_out <= wr_nib;
          end
        end
        DRAIN: begin
          state       <= IDLE;
          bus_command <= BUSCMD_NOP;
          busy        <= 1'b0;
          done        <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hp48_bus_ctrl.sv
// Directed bench for hp48_bus_ctrl: write, read-back, PC read, back-to-back
// request on the done cycle, reset abort and the no-device error flag.
module tb_hp48_bus_ctrl;

  localparam int MAXN = 16;
`ifdef HP48_BUS_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic            strobe;
  logic            reset;
  logic            req;
  logic            req_write;
  logic            req_use_pc;
  logic [19:0]     req_addr;
  logic [3:0]      req_len;
  logic [4*MAXN-1:0] wr_data;
  logic [3:0]      bus_nibble_in;
  logic            bus_active;
  logic [3:0]      bus_command;
  logic [19:0]     bus_address;
  logic [3:0]      bus_nibble_out;
  logic [4*MAXN-1:0] rd_data;
  logic            busy;
  logic            done;
  logic            err;
  logic [1:0]      state_dbg;

  int n_checks = 0;
  int n_fails  = 0;

  hp48_bus_ctrl #(.MAX_NIBBLES(MAXN)) dut (
    .strobe         (strobe),
    .reset          (reset),
    .req            (req),
    .req_write      (req_write),
    .req_use_pc     (req_use_pc),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .wr_data        (wr_data),
    .bus_nibble_in  (bus_nibble_in),
    .bus_active     (bus_active),
    .bus_command    (bus_command),
    .bus_address    (bus_address),
    .bus_nibble_out (bus_nibble_out),
    .rd_data        (rd_data),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .state_dbg      (state_dbg)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    strobe = 1'b0;
    forever #5 strobe = ~strobe;
  end

  task automatic tick();
    @(posedge strobe);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic wr, input logic pc, input logic [19:0] a, input logic [3:0] l);
    req        = 1'b1;
    req_write  = wr;
    req_use_pc = pc;
    req_addr   = a;
    req_len    = l;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; req_write = 1'b0; req_use_pc = 1'b0;
    req_addr = 20'h0; req_len = 4'h0; wr_data = '0;
    bus_nibble_in = 4'h0; bus_active = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_cmd",   bus_command, 4'h0);
    check("rst_addr",  bus_address, 20'h0);
    check("rst_nib",   bus_nibble_out, 4'h0);
    check("rst_rd",    rd_data, 64'h0);
    check("rst_busy",  busy, 1'b0);
    check("rst_done",  done, 1'b0);
    check("rst_err",   err, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    #8 reset = 1'b1;
    tick();

    // DP write of 4 nibbles at 0x80000; done on edge 6; req while busy ignored.
    wr_data = 64'h4321;
    start_req(1'b1, 1'b0, 20'h80000, 4'd3);
    tick();                                   // edge 1
    req = 1'b0; req_addr = 20'h11111;
    check("wr_load_cmd",  bus_command, 4'h7);
    check("wr_load_addr", bus_address, 20'h80000);
    check("wr_load_busy", busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();                                 // edges 2..5
      if (k == 1) req = 1'b1;
      if (k == 2) req = 1'b0;
      check("wr_cmd",  bus_command, 4'h5);
      check("wr_nib",  bus_nibble_out, 4'(k + 1));
      check("wr_done", done, 1'b0);
      check("wr_addr_hold", bus_address, 20'h80000);
    end
    tick();                                   // edge 6
    check("wr_done6", done, 1'b1);
    check("wr_cmd6",  bus_command, 4'h0);
    check("wr_busy6", busy, 1'b0);
    tick();
    check("wr_done_pulse", done, 1'b0);

    // DP read-back; device answers 1,2,3,4 one cycle after each command.
    start_req(1'b0, 1'b0, 20'h80000, 4'd3);
    tick();                                   // edge 1
    req = 1'b0;
    check("rd_load_cmd", bus_command, 4'h7);
    tick();                                   // edge 2
    check("rd_cmd2", bus_command, 4'h3);
    for (int k = 0; k < 3; k++) begin
      tick();                                 // edges 3..5
      check("rd_cmd", bus_command, 4'h3);
      check("rd_done", done, 1'b0);
      bus_nibble_in = 4'(k + 1);
    end
    tick();                                   // edge 6
    check("rd_drain_cmd",   bus_command, 4'h0);
    check("rd_drain_state", state_dbg, 2'd3);
    check("rd_drain_done",  done, 1'b0);
    bus_nibble_in = 4'h4;
    tick();                                   // edge 7
    bus_nibble_in = 4'hF;
    check("rd_done7", done, 1'b1);
    check("rd_data",  rd_data, 64'h4321);

    // PC read of one nibble, requested during the done cycle.
    start_req(1'b0, 1'b1, 20'h12345, 4'd0);
    tick();                                   // edge 1
    req = 1'b0;
    check("pc_load_cmd",  bus_command, 4'h6);
    check("pc_load_addr", bus_address, 20'h12345);
    check("pc_load_done", done, 1'b0);
    tick();                                   // edge 2
    check("pc_read_cmd", bus_command, 4'h2);
    tick();                                   // edge 3
    check("pc_drain_cmd", bus_command, 4'h0);
    bus_nibble_in = 4'hA;
    tick();                                   // edge 4
    check("pc_done", done, 1'b1);
    check("pc_rd_data", rd_data, 64'h432A);
    tick();

    // Reset during XFER aborts immediately with no done pulse.
    wr_data = 64'hBA98;
    start_req(1'b1, 1'b0, 20'h00040, 4'd3);
    tick();
    req = 1'b0;
    tick();
    check("ab_xfer_cmd", bus_command, 4'h5);
    #2 reset = 1'b0;
    #1;
    check("ab_cmd",   bus_command, 4'h0);
    check("ab_busy",  busy, 1'b0);
    check("ab_state", state_dbg, 2'd0);
    check("ab_nib",   bus_nibble_out, 4'h0);
    check("ab_rd",    rd_data, 64'h0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ab_no_done", done, 1'b0);
      check("ab_idle_cmd", bus_command, 4'h0);
    end

    // Next request after the abort runs normally: 2-nibble write.
    start_req(1'b1, 1'b0, 20'hFFFFF, 4'd1);
    tick();
    req = 1'b0;
    check("pr_load_addr", bus_address, 20'hFFFFF);
    tick();
    check("pr_nib0", bus_nibble_out, 4'h8);
    tick();
    check("pr_nib1", bus_nibble_out, 4'h9);
    check("pr_done3", done, 1'b0);
    tick();
    check("pr_done4", done, 1'b1);

    // No device on the 2nd XFER cycle: err sets (feature on), done still pulses.
    start_req(1'b0, 1'b0, 20'h00100, 4'd3);
    tick();
    req = 1'b0;
    tick();                                   // edge 2: XFER cycle 1
    tick();                                   // edge 3: XFER cycle 2
    bus_active = 1'b0;
    bus_nibble_in = 4'h5;
    check("er_before", err, 1'b0);
    tick();                                   // edge 4
    bus_active = 1'b1;
    check("er_set", err, ERR_EXP);
    tick();
    tick();
    tick();                                   // edge 7
    check("er_done", done, 1'b1);
    check("er_sticky", err, ERR_EXP);
    start_req(1'b0, 1'b1, 20'h00200, 4'd0);
    tick();
    req = 1'b0;
    check("er_clear", err, 1'b0);
    tick();
    tick();
    tick();
    check("er_next_done", done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
